// File: rtl/reservation_station_pkg.sv
// ---------------------------------------------------------------------------
// reservation_station_pkg
//   Shared types and default widths for the reservation station. Dispatch and
//   the writeback stage use the same rs_entry_t and width defaults.
//   Contents:
//     RS_XLEN / RS_TAG_W / RS_OP_W / RS_DEPTH  default widths and depth
//     rs_src_t    one source operand {rdy, val, tag}
//     rs_entry_t  one station entry {valid, op, dest_tag, src1, src2}
//     rs_snoop()  apply one CDB broadcast to a source operand
// ---------------------------------------------------------------------------
package reservation_station_pkg;

  localparam int unsigned RS_XLEN  = 32;
  localparam int unsigned RS_TAG_W = 8;
  localparam int unsigned RS_OP_W  = 8;
  localparam int unsigned RS_DEPTH = 4;

  typedef struct packed {
    logic                rdy;
    logic [RS_XLEN-1:0]  val;
    logic [RS_TAG_W-1:0] tag;
  } rs_src_t;

  typedef struct packed {
    logic                valid;
    logic [RS_OP_W-1:0]  op;
    logic [RS_TAG_W-1:0] dest_tag;
    rs_src_t             src1;
    rs_src_t             src2;
  } rs_entry_t;

  // A waiting source captures the broadcast value when its producer tag matches.
  function automatic rs_src_t rs_snoop(rs_src_t s, logic cdb_valid,
                                       logic [RS_TAG_W-1:0] cdb_tag,
                                       logic [RS_XLEN-1:0] cdb_result);
    rs_src_t o;
    o = s;
    if (cdb_valid && !s.rdy && (s.tag == cdb_tag)) begin
      o.rdy = 1'b1;
      o.val = cdb_result;
    end
    return o;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// ---------------------------------------------------------------------------
// reservation_station_if
//   Dispatch, CDB and functional-unit signals of the reservation station.
//   slave  : the station (consumes alloc_* / cdb_* / issue_ready)
//   master : the environment (dispatch, writeback CDB, functional unit)
//   alloc_* : valid/ready dispatch handshake with op, dest tag, two sources
//   cdb_*   : broadcast valid, tag and result
//   issue_* : valid/ready handshake towards the functional unit
// ---------------------------------------------------------------------------
interface reservation_station_if
  import reservation_station_pkg::*;
#(
  parameter int unsigned XLEN  = RS_XLEN,
  parameter int unsigned TAG_W = RS_TAG_W,
  parameter int unsigned OP_W  = RS_OP_W
) ();

  logic             alloc_valid;
  logic             alloc_ready;
  logic [OP_W-1:0]  alloc_op;
  logic [TAG_W-1:0] alloc_dest_tag;
  logic             alloc_src1_rdy;
  logic [XLEN-1:0]  alloc_src1_val;
  logic [TAG_W-1:0] alloc_src1_tag;
  logic             alloc_src2_rdy;
  logic [XLEN-1:0]  alloc_src2_val;
  logic [TAG_W-1:0] alloc_src2_tag;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_result;

  logic             issue_valid;
  logic             issue_ready;
  logic [OP_W-1:0]  issue_op;
  logic [XLEN-1:0]  issue_src1;
  logic [XLEN-1:0]  issue_src2;
  logic [TAG_W-1:0] issue_dest_tag;

  modport slave (
    input  alloc_valid, alloc_op, alloc_dest_tag,
           alloc_src1_rdy, alloc_src1_val, alloc_src1_tag,
           alloc_src2_rdy, alloc_src2_val, alloc_src2_tag,
           cdb_valid, cdb_tag, cdb_result, issue_ready,
    output alloc_ready, issue_valid, issue_op, issue_src1, issue_src2,
           issue_dest_tag
  );

  modport master (
    output alloc_valid, alloc_op, alloc_dest_tag,
           alloc_src1_rdy, alloc_src1_val, alloc_src1_tag,
           alloc_src2_rdy, alloc_src2_val, alloc_src2_tag,
           cdb_valid, cdb_tag, cdb_result, issue_ready,
    input  alloc_ready, issue_valid, issue_op, issue_src1, issue_src2,
           issue_dest_tag
  );

endinterface

// File: rtl/reservation_station_age_matrix.sv
// ---------------------------------------------------------------------------
// rs_age_matrix
//   DEPTH x DEPTH age matrix. older_q[i][j]=1 means entry i was allocated
//   before entry j. Picks the oldest requester as a one-hot mask.
//   clk, rst_n : clock, asynchronous active-low reset
//   alloc_i    : one-hot slot being allocated this cycle (or zero)
//   free_i     : one-hot slot being freed this cycle (or zero)
//   req_i      : slots competing for selection
//   oldest_o   : one-hot oldest requester (zero when no request)
// ---------------------------------------------------------------------------
module rs_age_matrix #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] oldest_o
);

  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  // A newcomer is younger than every slot: set its column, clear its row.
  // Bits of an empty slot are don't-care until it is allocated again.
  always_comb begin
    older_d = older_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (alloc_i[j] && (i != j)) older_d[i][j] = 1'b1;
        if (alloc_i[i])             older_d[i][j] = 1'b0;
        if (free_i[i] || free_i[j]) older_d[i][j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  // A requester wins when no other requester is older than it.
  always_comb begin
    oldest_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (req_i[j] && older_q[j][i]) blocked = 1'b1;
      end
      oldest_o[i] = req_i[i] && !blocked;
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//   Tomasulo reservation station holding up to DEPTH operations. Operands are
//   values or producer tags; pending tags are captured from the CDB. The
//   oldest entry with both operands ready is presented to the functional unit.
//   clk       : clock
//   rst_n     : asynchronous active-low reset (invalidates all entries)
//   flush     : synchronous squash; also gates issue_valid while high
//   rs        : dispatch / CDB / issue bundle (reservation_station_if.slave)
//   occupancy : number of valid entries
// ---------------------------------------------------------------------------
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned XLEN  = RS_XLEN,
  parameter int unsigned TAG_W = RS_TAG_W,
  parameter int unsigned OP_W  = RS_OP_W,
  parameter int unsigned DEPTH = RS_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  reservation_station_if.slave         rs,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             rdy;
    logic [XLEN-1:0]  val;
    logic [TAG_W-1:0] tag;
  } src_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dest_tag;
    src_t             src1;
    src_t             src2;
  } entry_t;

  function automatic src_t snoop(src_t s, logic v, logic [TAG_W-1:0] t,
                                 logic [XLEN-1:0] r);
    src_t o;
    o = s;
    if (v && !s.rdy && (s.tag == t)) begin
      o.rdy = 1'b1;
      o.val = r;
    end
    return o;
  endfunction

  logic [DEPTH-1:0] valid_q, valid_d;
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];

  logic [DEPTH-1:0] free_oh, alloc_oh, req, grant, age_alloc, age_free;
  logic             alloc_fire, issue_fire, issue_vld;
  entry_t           new_ent;
  logic [OP_W-1:0]  sel_op;
  logic [TAG_W-1:0] sel_dest;
  logic [XLEN-1:0]  sel_src1, sel_src2;

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) occupancy = occupancy + CNT_W'(valid_q[i]);
  end

  // Uses registered occupancy, so a slot freed by this cycle's issue stays
  // unavailable until the next cycle.
  assign rs.alloc_ready = (occupancy < CNT_W'(DEPTH));
  assign alloc_fire     = rs.alloc_valid && rs.alloc_ready && !flush;

  // Lowest-index free slot.
  always_comb begin
    logic found;
    found   = 1'b0;
    free_oh = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end
  assign alloc_oh = alloc_fire ? free_oh : '0;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++)
      req[i] = valid_q[i] && ent_q[i].src1.rdy && ent_q[i].src2.rdy;
  end

  assign issue_vld  = (|req) && !flush;
  assign issue_fire = issue_vld && rs.issue_ready;
  assign age_alloc  = alloc_oh;
  assign age_free   = issue_fire ? grant : '0;

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk      (clk),
    .rst_n    (rst_n),
    .alloc_i  (age_alloc),
    .free_i   (age_free),
    .req_i    (req),
    .oldest_o (grant)
  );

  always_comb begin
    sel_op   = '0;
    sel_dest = '0;
    sel_src1 = '0;
    sel_src2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_op   = ent_q[i].op;
        sel_dest = ent_q[i].dest_tag;
        sel_src1 = ent_q[i].src1.val;
        sel_src2 = ent_q[i].src2.val;
      end
    end
  end

  assign rs.issue_valid    = issue_vld;
  assign rs.issue_op       = issue_vld ? sel_op   : '0;
  assign rs.issue_dest_tag = issue_vld ? sel_dest : '0;
  assign rs.issue_src1     = issue_vld ? sel_src1 : '0;
  assign rs.issue_src2     = issue_vld ? sel_src2 : '0;

  // Incoming op, with same-cycle CDB bypass for pending sources.
  always_comb begin
    new_ent.op       = rs.alloc_op;
    new_ent.dest_tag = rs.alloc_dest_tag;
    new_ent.src1     = snoop('{rdy: rs.alloc_src1_rdy, val: rs.alloc_src1_val,
                               tag: rs.alloc_src1_tag},
                             rs.cdb_valid, rs.cdb_tag, rs.cdb_result);
    new_ent.src2     = snoop('{rdy: rs.alloc_src2_rdy, val: rs.alloc_src2_val,
                               tag: rs.alloc_src2_tag},
                             rs.cdb_valid, rs.cdb_tag, rs.cdb_result);
  end

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        ent_d[i].src1 = snoop(ent_q[i].src1, rs.cdb_valid, rs.cdb_tag, rs.cdb_result);
        ent_d[i].src2 = snoop(ent_q[i].src2, rs.cdb_valid, rs.cdb_tag, rs.cdb_result);
      end
    end
    if (issue_fire) valid_d = valid_d & ~grant;
    if (alloc_fire) begin
      valid_d = valid_d | alloc_oh;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) ent_d[i] = new_ent;
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] occupancy;

  int n_vec = 0;
  int n_err = 0;

  rs_entry_t mq[$];   // model: valid entries, oldest first

  always #5 clk = ~clk;

  reservation_station_if bus ();

  reservation_station #(
    .XLEN(32), .TAG_W(8), .OP_W(8), .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rs        (bus),
    .occupancy (occupancy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_sel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].src1.rdy && mq[i].src2.rdy) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    int s;
    logic [7:0]  e_op, e_dest;
    logic [31:0] e_s1, e_s2;
    s = flush ? -1 : model_sel();
    e_op = '0; e_dest = '0; e_s1 = '0; e_s2 = '0;
    if (s >= 0) begin
      e_op = mq[s].op; e_dest = mq[s].dest_tag;
      e_s1 = mq[s].src1.val; e_s2 = mq[s].src2.val;
    end
    chk("issue_valid", 64'(bus.issue_valid), 64'(s >= 0));
    chk("issue_op",    64'(bus.issue_op), 64'(e_op));
    chk("issue_dest",  64'(bus.issue_dest_tag), 64'(e_dest));
    chk("issue_src1",  64'(bus.issue_src1), 64'(e_s1));
    chk("issue_src2",  64'(bus.issue_src2), 64'(e_s2));
    chk("alloc_ready", 64'(bus.alloc_ready), 64'(mq.size() < DEPTH));
    chk("occupancy",   64'(occupancy), 64'(mq.size()));
  endtask

  task automatic model_edge();
    int s;
    bit can_alloc;
    rs_entry_t e;
    if (!rst_n || flush) begin
      mq.delete();
      return;
    end
    can_alloc = bus.alloc_valid && (mq.size() < DEPTH);
    s = model_sel();
    if (s >= 0 && bus.issue_ready) mq.delete(s);
    if (can_alloc) begin
      e.valid = 1'b1;
      e.op = bus.alloc_op;
      e.dest_tag = bus.alloc_dest_tag;
      e.src1.rdy = bus.alloc_src1_rdy; e.src1.val = bus.alloc_src1_val; e.src1.tag = bus.alloc_src1_tag;
      e.src2.rdy = bus.alloc_src2_rdy; e.src2.val = bus.alloc_src2_val; e.src2.tag = bus.alloc_src2_tag;
      mq.push_back(e);
    end
    for (int i = 0; i < mq.size(); i++) begin
      mq[i].src1 = rs_snoop(mq[i].src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_result);
      mq[i].src2 = rs_snoop(mq[i].src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_result);
    end
  endtask

  // Check at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_alloc(input logic v, input logic [7:0] op, input logic [7:0] dest,
                             input logic r1, input logic [31:0] v1, input logic [7:0] t1,
                             input logic r2, input logic [31:0] v2, input logic [7:0] t2);
    bus.alloc_valid = v; bus.alloc_op = op; bus.alloc_dest_tag = dest;
    bus.alloc_src1_rdy = r1; bus.alloc_src1_val = v1; bus.alloc_src1_tag = t1;
    bus.alloc_src2_rdy = r2; bus.alloc_src2_val = v2; bus.alloc_src2_tag = t2;
  endtask

  task automatic drive_cdb(input logic v, input logic [7:0] tag, input logic [31:0] res);
    bus.cdb_valid = v; bus.cdb_tag = tag; bus.cdb_result = res;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_issue_valid"}, 64'(bus.issue_valid), 64'(0));
    chk({tag, "_issue_op"},    64'(bus.issue_op), 64'(0));
    chk({tag, "_issue_src1"},  64'(bus.issue_src1), 64'(0));
    chk({tag, "_issue_src2"},  64'(bus.issue_src2), 64'(0));
    chk({tag, "_issue_dest"},  64'(bus.issue_dest_tag), 64'(0));
    chk({tag, "_alloc_ready"}, 64'(bus.alloc_ready), 64'(1));
    chk({tag, "_occupancy"},   64'(occupancy), 64'(0));
  endtask

  initial begin
    drive_alloc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(0, 0, 0);
    bus.issue_ready = 1'b1;
    #1;
    check_reset("reset");
    step();
    rst_n = 1'b1;

    // Both operands ready: eligible one cycle after allocation.
    drive_alloc(1, 8'h11, 8'h21, 1, 32'd5, 0, 1, 32'd7, 0);
    step();
    drive_alloc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("a_valid", 64'(bus.issue_valid), 64'(1));
    chk("a_src1",  64'(bus.issue_src1), 64'(5));
    chk("a_src2",  64'(bus.issue_src2), 64'(7));
    chk("a_dest",  64'(bus.issue_dest_tag), 64'h21);
    chk("a_occ1",  64'(occupancy), 64'(1));
    step();
    chk("a_occ0",  64'(occupancy), 64'(0));

    // Pending src1 woken by a later broadcast.
    drive_alloc(1, 8'h12, 8'h22, 0, 0, 8'h03, 1, 32'd1, 0);
    step();
    drive_alloc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("b_wait", 64'(bus.issue_valid), 64'(0));
    drive_cdb(1, 8'h03, 32'hDEAD);
    step();
    drive_cdb(0, 0, 0);
    chk("b_valid", 64'(bus.issue_valid), 64'(1));
    chk("b_src1",  64'(bus.issue_src1), 64'hDEAD);
    step();

    // Allocation bypass on both sources.
    drive_alloc(1, 8'h13, 8'h23, 0, 0, 8'h04, 0, 0, 8'h04);
    drive_cdb(1, 8'h04, 32'd9);
    step();
    drive_alloc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(0, 0, 0);
    chk("c_valid", 64'(bus.issue_valid), 64'(1));
    chk("c_src1",  64'(bus.issue_src1), 64'(9));
    chk("c_src2",  64'(bus.issue_src2), 64'(9));
    step();

    // Fill, refuse a fifth, then wake entry 3 before entry 1.
    bus.issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_alloc(1, 8'(8'h30 + k), 8'(8'h40 + k), 0, 0, 8'(8'h50 + 2*k), 0, 0, 8'(8'h51 + 2*k));
      step();
    end
    drive_alloc(1, 8'h34, 8'h44, 1, 1, 0, 1, 1, 0);
    chk("d_full_ready", 64'(bus.alloc_ready), 64'(0));
    step();
    drive_alloc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("d_full_occ", 64'(occupancy), 64'(4));
    drive_cdb(1, 8'h56, 32'h300); step();
    drive_cdb(1, 8'h57, 32'h301); step();
    drive_cdb(0, 0, 0);
    chk("d_e3_dest", 64'(bus.issue_dest_tag), 64'h43);
    drive_cdb(1, 8'h52, 32'h100); step();
    drive_cdb(1, 8'h53, 32'h101); step();
    drive_cdb(0, 0, 0);
    chk("d_e1_dest", 64'(bus.issue_dest_tag), 64'h41);
    chk("d_e1_src1", 64'(bus.issue_src1), 64'h100);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("d_hold_valid", 64'(bus.issue_valid), 64'(1));
      chk("d_hold_dest",  64'(bus.issue_dest_tag), 64'h41);
    end
    bus.issue_ready = 1'b1;
    step();
    chk("d_next_dest", 64'(bus.issue_dest_tag), 64'h43);
    chk("d_occ3", 64'(occupancy), 64'(3));
    drive_alloc(1, 8'h35, 8'h45, 1, 32'hA, 0, 1, 32'hB, 0);
    step();
    drive_alloc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.issue_ready = 1'b0;
    chk("d_occ_same", 64'(occupancy), 64'(3));
    chk("d_new_dest", 64'(bus.issue_dest_tag), 64'h45);

    // Flush with three valid entries and a concurrent alloc.
    flush = 1'b1;
    drive_alloc(1, 8'h36, 8'h46, 1, 1, 0, 1, 2, 0);
    drive_cdb(1, 8'h50, 32'd7);
    #1;
    chk("f_gate", 64'(bus.issue_valid), 64'(0));
    step();
    flush = 1'b0;
    drive_alloc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(0, 0, 0);
    chk("f_occ", 64'(occupancy), 64'(0));
    chk("f_valid", 64'(bus.issue_valid), 64'(0));
    step();
    chk("f_dropped", 64'(occupancy), 64'(0));

    // Asynchronous reset in the middle of a wakeup.
    drive_alloc(1, 8'h37, 8'h47, 1, 3, 0, 1, 4, 0); step();
    drive_alloc(1, 8'h38, 8'h48, 0, 0, 8'h60, 1, 5, 0); step();
    drive_alloc(1, 8'h39, 8'h49, 1, 6, 0, 1, 7, 0);
    drive_cdb(1, 8'h60, 32'h77);
    rst_n = 1'b0;
    mq.delete();
    #1;
    check_reset("rst_mid");
    step();
    chk("rst_hold_occ", 64'(occupancy), 64'(0));
    drive_alloc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(0, 0, 0);
    rst_n = 1'b1;

    // Random traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      drive_alloc(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 7)));
      drive_cdb(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom);
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0;
    drive_alloc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(0, 0, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Tomasulo-style reservation station that consumes the common data bus (CDB) driven by the writeback stage. It holds up to DEPTH dispatched operations whose source operands are either values or producer tags. It snoops CDB broadcasts to capture pending operands and issues the oldest fully-ready entry to its functional unit over a valid/ready handshake.

## Interface
- XLEN, 32, operand/result width
- TAG_W, 8, physical/ROB tag width; matches the CDB tag
- OP_W, 8, opaque micro-op field width
- DEPTH, 4, number of entries (power of two, ≥2)
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries
- alloc_valid  in  1  dispatch offers an operation
- alloc_ready  out  1  station accepts an operation this cycle
- alloc_op  in  OP_W  micro-op
- alloc_dest_tag  in  TAG_W  tag this op will broadcast on the CDB
- alloc_src1_rdy / alloc_src2_rdy  in  1  operand already a value
- alloc_src1_val / alloc_src2_val  in  XLEN  operand value (used when rdy=1)
- alloc_src1_tag / alloc_src2_tag  in  TAG_W  producer tag (used when rdy=0)
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_result  in  XLEN  broadcast value
- issue_valid  out  1  an entry with both operands ready is presented
- issue_ready  in  1  functional unit accepts
- issue_op  out  OP_W;  issue_src1 / issue_src2  out  XLEN;  issue_dest_tag  out  TAG_W
- occupancy  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Entry state: valid, op, dest_tag, per-source {rdy, val, tag}.
- Allocation: when alloc_valid && alloc_ready && !flush, write into the lowest-index free entry. The new entry is the youngest.
- Allocation bypass: for a source with rdy=0, if cdb_valid and cdb_tag equals that source tag in the same cycle, the entry stores cdb_result with rdy=1.
- Wakeup: every valid entry source with rdy=0 and tag==cdb_tag while cdb_valid latches cdb_result and sets rdy. Both sources of one entry may wake on the same broadcast. Any number of entries may wake on one broadcast.
- Select: among valid entries with both rdy, present the oldest. Age ordering comes from an age matrix updated on allocation.
- Issue outputs are combinational from registered state. They are zero when issue_valid=0.
- Issue: issue_valid && issue_ready frees the selected entry at the clock edge.
- alloc_ready = (occupancy < DEPTH). A slot freed by an issue in the same cycle is not reusable until the next cycle.
- Simultaneous alloc and issue: occupancy is unchanged.
- flush: all valid bits clear at the next edge. Same-cycle alloc and issue are dropped, and issue_valid is forced 0 while flush=1.
- Reset mid-operation: all entries are invalidated immediately. CDB and alloc inputs are ignored while rst_n=0.

## Timing
- Reset values: issue_valid=0, issue_op/src1/src2/dest_tag=0, alloc_ready=1, occupancy=0.
- Alloc → issue: an entry allocated with both operands ready (or bypassed) at edge t is eligible in cycle t+1. Minimum latency is 1 cycle.
- CDB wakeup at cycle t → entry eligible in cycle t+1.
- issue_valid may change only after a clock edge or flush. Once asserted, the presented entry stays stable until accepted, unless an older entry becomes ready, flush, or reset occurs.
- occupancy updates at the same edge as alloc/issue/flush.

## Structure
- A shared package holds rs_entry_t (the entry struct) and the TAG_W/XLEN defaults, shared with the writeback stage and dispatch.
- One sub-module, rs_age_matrix: a DEPTH×DEPTH bit matrix with set-on-alloc and clear-on-free. It outputs a one-hot oldest-among-request-mask.

## Test plan
- Reset, then alloc {op=0x11, src1 rdy=5, src2 rdy=7, dest=0x21} → next cycle issue_valid=1, src1=5, src2=7, dest_tag=0x21. occupancy goes 1 then 0 after accept.
- Alloc src1 tag=0x03 (not ready) → no issue. Broadcast cdb {tag=0x03, result=0xDEAD} → issue the following cycle with src1=0xDEAD.
- Alloc src1 and src2 tag=0x04 in the same cycle cdb broadcasts tag 0x04, value 9 → entry issues next cycle with src1=src2=9.
- Fill 4 entries with all sources waiting on distinct tags → alloc_ready=0 and the 5th alloc is refused. Wake entries in the order 3,1 → issue order is entry1 (older) then entry3.
- Hold issue_ready=0 for 3 cycles → the same entry is presented stably. Accept together with a new alloc → occupancy unchanged.
- With 3 valid entries, assert flush with alloc_valid=1 → occupancy=0 next cycle, no issue, and the alloc is dropped. Assert rst_n=0 mid-wakeup → outputs return to reset values immediately.
